// File: rtl/mmio_tile_fb_if.sv
// Bus bundle for mmio_tile_fb: CPU address/data/strobe, VGA pixel coordinates,
// and the DAC / read-data outputs.
interface mmio_tile_fb_if;
    logic        cpu_clk;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic [9:0]  x_addr;
    logic [9:0]  y_addr;
    logic [9:0]  vga_r;
    logic [9:0]  vga_g;
    logic [9:0]  vga_b;
    logic [7:0]  rd_data;

    modport master (
        output cpu_clk, addr, data, rw, x_addr, y_addr,
        input  vga_r, vga_g, vga_b, rd_data
    );

    modport slave (
        input  cpu_clk, addr, data, rw, x_addr, y_addr,
        output vga_r, vga_g, vga_b, rd_data
    );
endinterface

// File: rtl/mmio_tile_fb.sv
// mmio_tile_fb: memory-mapped tile framebuffer, 16-entry RRRGGGBB palette, 2-cycle pixel pipeline.
// Optional macro FB_SCROLL_EN adds wrapping tile-unit scroll registers at SCROLL_ADDR.
module mmio_tile_fb #(
    parameter logic [15:0] BASE_ADDR   = 16'h0200,
    parameter logic [15:0] PAL_ADDR    = 16'h0600,
    parameter logic [15:0] SCROLL_ADDR = 16'h0610,
    parameter int unsigned COLS        = 32,
    parameter int unsigned ROWS        = 32,
    parameter int unsigned TILE_SHIFT  = 4,
    parameter int unsigned ACTIVE_W    = 480,
    parameter logic [7:0]  BORDER_RGB  = 8'h1C
) (
    input logic           CLOCK_50,
    input logic           reset,
    mmio_tile_fb_if.slave bus
);
    localparam int unsigned CB     = $clog2(COLS);
    localparam int unsigned RB     = $clog2(ROWS);
    localparam int unsigned IDX_W  = CB + RB;
    localparam int unsigned NTILES = COLS * ROWS;

    localparam logic [16:0] TILE_LO  = {1'b0, BASE_ADDR};
    localparam logic [16:0] TILE_HI  = {1'b0, BASE_ADDR} + 17'(NTILES);
    localparam logic [16:0] PAL_LO   = {1'b0, PAL_ADDR};
    localparam logic [16:0] PAL_HI   = {1'b0, PAL_ADDR} + 17'd16;
    localparam logic [9:0]  COLS_X   = 10'(COLS);
    localparam logic [9:0]  ROWS_Y   = 10'(ROWS);
    localparam logic [9:0]  ACTIVE_X = 10'(ACTIVE_W);

    typedef enum logic [1:0] {REG_BLANK, REG_BORDER, REG_TILE} region_e;

    function automatic logic [29:0] expand_rgb(input logic [7:0] c);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[7:5];
        g = c[4:2];
        b = c[1:0];
        return {r, r, r, r[2], g, g, g, g[2], b, b, b, b, b};
    endfunction

    logic              prev_cpu_clk_q;
    logic              wstb;
    logic [16:0]       addr_ext;
    logic              tile_hit;
    logic              pal_hit;
    logic              scroll_hit;
    logic [IDX_W-1:0]  cpu_idx;
    logic [3:0]        pal_idx;
    logic [7:0]        scroll_rd;

    logic [7:0]        tile_ram [NTILES];
    logic [7:0]        palette_q [16];
    logic [7:0]        rd_data_q;
    logic [7:0]        rd_data_d;

    logic [9:0]        tx_p0;
    logic [9:0]        ty_p0;
    logic [CB-1:0]     tx_s_p0;
    logic [RB-1:0]     ty_s_p0;
    logic [IDX_W-1:0]  idx_p0;
    region_e           region_p0;

    logic              vld_p1;
    region_e           region_p1;
    logic [3:0]        nib_p1;

    logic [7:0]        rgb_p2;
    logic [29:0]       vga_q;
    logic [29:0]       vga_d;

    // A write fires once, on the CLOCK_50 cycle that sees the CPU clock fall.
    assign wstb = prev_cpu_clk_q & ~bus.cpu_clk & ~bus.rw;

    assign addr_ext   = {1'b0, bus.addr};
    assign tile_hit   = (addr_ext >= TILE_LO) && (addr_ext < TILE_HI);
    assign pal_hit    = (addr_ext >= PAL_LO) && (addr_ext < PAL_HI);
    assign scroll_hit = (bus.addr == SCROLL_ADDR) || (bus.addr == SCROLL_ADDR + 16'd1);
    assign cpu_idx    = IDX_W'(bus.addr - BASE_ADDR);
    assign pal_idx    = 4'(bus.addr - PAL_ADDR);

    always_ff @(posedge CLOCK_50) begin
        if (reset) prev_cpu_clk_q <= 1'b0;
        else       prev_cpu_clk_q <= bus.cpu_clk;
    end

    always_ff @(posedge CLOCK_50) begin
        if (wstb && tile_hit) tile_ram[cpu_idx] <= bus.data;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) palette_q[i] <= (i == 0) ? 8'h00 : 8'hFF;
        end else if (wstb && pal_hit) begin
            palette_q[pal_idx] <= bus.data;
        end
    end

`ifdef FB_SCROLL_EN
    logic [7:0] sx_q;
    logic [7:0] sy_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sx_q <= 8'h00;
            sy_q <= 8'h00;
        end else if (wstb && scroll_hit) begin
            if (bus.addr == SCROLL_ADDR) sx_q <= bus.data;
            else                         sy_q <= bus.data;
        end
    end

    assign scroll_rd = (bus.addr == SCROLL_ADDR) ? sx_q : sy_q;
    assign tx_s_p0   = CB'(tx_p0 + {2'b00, sx_q});
    assign ty_s_p0   = RB'(ty_p0 + {2'b00, sy_q});
`else
    assign scroll_rd = 8'h00;
    assign tx_s_p0   = tx_p0[CB-1:0];
    assign ty_s_p0   = ty_p0[RB-1:0];
`endif

    always_comb begin
        rd_data_d = 8'h00;
        if (tile_hit)        rd_data_d = tile_ram[cpu_idx];
        else if (pal_hit)    rd_data_d = palette_q[pal_idx];
        else if (scroll_hit) rd_data_d = scroll_rd;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) rd_data_q <= 8'h00;
        else       rd_data_q <= rd_data_d;
    end

    // ---- stage 0: tile coordinates, index and region class ----
    assign tx_p0  = bus.x_addr >> TILE_SHIFT;
    assign ty_p0  = bus.y_addr >> TILE_SHIFT;
    assign idx_p0 = {ty_s_p0, tx_s_p0};

    always_comb begin
        region_p0 = REG_TILE;
        if (bus.x_addr == 10'h3ff || bus.y_addr == 10'h3ff)
            region_p0 = REG_BLANK;
        else if (bus.x_addr >= ACTIVE_X || tx_p0 >= COLS_X || ty_p0 >= ROWS_Y)
            region_p0 = REG_BORDER;
    end

    // ---- stage 1: tile RAM read, region carried alongside ----
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            region_p1 <= REG_BLANK;
        end else begin
            vld_p1    <= 1'b1;
            region_p1 <= region_p0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        nib_p1 <= tile_ram[idx_p0][3:0];
    end

    // ---- stage 2: palette lookup, DAC expansion, output register ----
    always_comb begin
        rgb_p2 = 8'h00;
        if (vld_p1) begin
            case (region_p1)
                REG_TILE:   rgb_p2 = palette_q[nib_p1];
                REG_BORDER: rgb_p2 = BORDER_RGB;
                default:    rgb_p2 = 8'h00;
            endcase
        end
    end

    assign vga_d = expand_rgb(rgb_p2);

    always_ff @(posedge CLOCK_50) begin
        if (reset) vga_q <= 30'd0;
        else       vga_q <= vga_d;
    end

    assign bus.vga_r   = vga_q[29:20];
    assign bus.vga_g   = vga_q[19:10];
    assign bus.vga_b   = vga_q[9:0];
    assign bus.rd_data = rd_data_q;
endmodule

// File: doc/mmio_tile_fb.md
Name: mmio_tile_fb

Overview:
- Parametrised memory-mapped tile framebuffer, successor to the fixed 32x32 monochrome screen block.
- Sits between the CPU bus (addr/data/rw, sampled CPU clock) and the VGA driver's pixel-coordinate outputs.
- Stores one byte per tile. The low nibble indexes a 16-entry palette register file (RRRGGGBB). Palette colours are expanded to 10-bit DAC values.
- Output pixels are registered with fixed latency, and out-of-area pixels get a border colour.

Parameters:
- BASE_ADDR, 16'h0200, CPU address of tile 0.
- PAL_ADDR, 16'h0600, CPU address of palette entry 0 (16 consecutive bytes).
- SCROLL_ADDR, 16'h0610, CPU address of scroll X (+0) and scroll Y (+1); used only with FB_SCROLL_EN.
- COLS, 32, tiles per row (power of two).
- ROWS, 32, tile rows (power of two).
- TILE_SHIFT, 4, log2 of tile edge in pixels (4 = 16x16).
- ACTIVE_W, 480, pixel columns drawn from tiles; x >= ACTIVE_W is border.
- BORDER_RGB, 8'h1C, RRRGGGBB border colour (pure green).

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_clk  in  1  CPU clock, sampled as data (not a clock domain).
- addr  in  16  CPU address.
- data  in  8  CPU write data.
- rw  in  1  0 = write, 1 = read.
- x_addr  in  10  current pixel x from VGA driver; 10'h3ff = blanking.
- y_addr  in  10  current pixel y from VGA driver; 10'h3ff = blanking.
- vga_r  out  10  red DAC value.
- vga_g  out  10  green DAC value.
- vga_b  out  10  blue DAC value.
- rd_data  out  8  CPU read data.

Behaviour:
- Reset:
  - vga_r, vga_g, vga_b = 0; rd_data = 0; prev_cpu_clk = 0; pipeline valid bits = 0; scroll registers = 0.
  - palette[0] = 8'h00; palette[1..15] = 8'hFF, so nonzero tiles render white.
  - Tile RAM contents are not reset.
- Write strobe: wstb = prev_cpu_clk & ~cpu_clk & ~rw. It lasts exactly one CLOCK_50 cycle per CPU falling edge. Holding rw=0 while cpu_clk stays high or low never writes.
- Address decode (exclusive ranges):
  - Tile: BASE_ADDR <= addr < BASE_ADDR + COLS*ROWS; index = addr - BASE_ADDR.
  - Palette: PAL_ADDR..PAL_ADDR+15.
  - Scroll: SCROLL_ADDR..+1.
  - Any other address: writes ignored.
- CPU read: rd_data is registered, 1-cycle latency, updated every cycle.
  - Tile range returns RAM byte; palette range returns the entry; scroll range returns the register (0 without FB_SCROLL_EN); otherwise 8'h00.
- Display pipeline, total latency 2 cycles from x_addr/y_addr to vga_*:
  - Stage 0 (comb): tx = x_addr >> TILE_SHIFT; ty = y_addr >> TILE_SHIFT; tile index = ty*COLS + tx. Index width is clog2(COLS*ROWS); multiplication is by shift.
  - Stage 0 (comb) region classes:
    - blank: x_addr or y_addr == 10'h3ff.
    - border: x_addr >= ACTIVE_W, or tx >= COLS, or ty >= ROWS.
    - tile: otherwise.
  - Stage 1: synchronous RAM read of the index; region class is registered alongside.
  - Stage 2: colour = palette[q[3:0]] for tile, BORDER_RGB for border, 8'h00 for blank.
    - Expansion: R3 -> {r,r,r,r[2]}; G3 likewise; B2 -> {b,b,b,b,b}.
    - Result registered onto vga_*.
  - Upper nibble of tile byte: ignored for colour, readable by CPU.
- Write/read collision: a CPU write to a tile read by the display in the same cycle shows old data for that pixel (read-before-write). A palette write takes effect for stage-2 pixels on the next cycle.
- Reset mid-frame: outputs go to 0 the next cycle; the pipeline refills within 2 cycles after deassert.

Optional Feature:
- Macro FB_SCROLL_EN.
- Defined:
  - Two 8-bit scroll registers sx, sy (tile units) are writable at SCROLL_ADDR.
  - Stage 0 uses tx' = (tx + sx) mod COLS and ty' = (ty + sy) mod ROWS, wrapping.
  - The border test still uses the unscrolled tx/ty.
- Undefined: registers absent; scroll writes ignored; reads return 0; mapping is identity.

Test Plan:
- Reset check: assert reset 2 cycles -> vga_* = 0, rd_data = 0. Then read 0x0601 -> 8'hFF and 0x0600 -> 8'h00.
- Tile write and render:
  - Setup: write 0x05 to 0x0200 via cpu_clk falling edge with rw=0; write 8'hE0 to 0x0605.
  - Stimulus: drive x=3, y=7.
  - Response: 2 cycles later vga_r = 10'h3ff, vga_g = 0, vga_b = 0.
- Border and blank:
  - x=480, y=0 -> vga_g = 10'h3ff, vga_r = 0, vga_b = 0.
  - x=10'h3ff -> all 0.
  - Also checks a pixel with ty >= ROWS (e.g. ROWS=16 build, y=300) -> border.
- Strobe qualification:
  - rw=0 with cpu_clk held high 10 cycles -> 0x0210 unchanged.
  - Single falling edge -> exactly one write, readback 1 cycle after address.
- Collision: write 0x01 to tile 0 in the same cycle the display reads tile 0 -> that pixel uses old value; the next pixel in tile 0 uses new.
- With FB_SCROLL_EN: write sx=1 and tile 1 = 0x03 with palette[3] = 8'h03 -> pixel (0,0) has vga_b = 10'h3ff. Set sx=31 -> tile 0 rendered at tx=1 (wrap).
